// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage placed directly after the pc block.
// The stage turns the current PC into word reads on a req/ack memory port.
// Returned instructions and their PCs are held in a small circular FIFO for
// decode. A flush (jump or taken branch) empties the FIFO. A flush also causes
// any in-flight fetch to be discarded when its ack arrives.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pc                current PC from the pc block
//   flush             redirect this cycle
//   pcAdvance         pulse telling the pc block to perform PC+4 on this edge
//   memReq, memAddr   registered read request and word address
//   memAck, memData   memory accepted the request; instruction word this cycle
//   instValid         FIFO head valid
//   instData, instPc  head instruction and its PC (both 0 when not valid)
//   instReady         decode consumes the head when instValid & instReady

module fetch_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pcAdvance,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic        instValid,
    output logic [31:0] instData,
    output logic [31:0] instPc,
    input  logic        instReady
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;

    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic            inst_valid;
    logic            push;
    logic            pop;
    logic [31:0]     occ_after_pop;
    logic            space;
    logic            keep_issuing;

    // The word address ignores the byte offset of the incoming PC.
    logic            unused_pc_low;
    assign unused_pc_low = ^pc[1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (32'(p) == DEPTH - 1) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign inst_valid    = (count_q != '0);
    assign pop           = inst_valid & instReady & ~flush;
    // pop only happens when count_q >= 1, so this cannot underflow
    assign occ_after_pop = 32'(count_q) - 32'(pop);
    assign space         = (occ_after_pop < DEPTH);
    // room for the entry being written now plus the next back-to-back fetch
    assign keep_issuing  = ((occ_after_pop + 32'd1) < DEPTH);
    assign push          = memAck & (state_q == StWait) & ~flush;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                if (space && !flush) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc[31:2], 2'b00};
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (memAck) begin
                    if (flush) begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end else if (keep_issuing) begin
                        mem_addr_d = mem_addr_q + 32'd4;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = StIdle;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn, so drop its data later.
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping; flush dominates any same-cycle push or pop
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage needs no reset: the outputs are gated by instValid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_q] <= memData;
            pc_mem[tail_q]   <= mem_addr_q;
        end
    end

    assign pcAdvance = push;
    assign memReq    = mem_req_q;
    assign memAddr   = mem_addr_q;
    assign instValid = inst_valid;
    assign instData  = inst_valid ? data_mem[head_q] : 32'd0;
    assign instPc    = inst_valid ? pc_mem[head_q] : 32'd0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer. Expected {pc, data} pairs are queued by the
// directed stimulus. A negedge monitor pops the queue and compares whenever
// decode consumes the FIFO head. The memory returns ~address unless the
// override is active. A tiny pc-block model advances on pcAdvance and jumps
// on flush.

module tb_fetch_buffer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        flush = 1'b0;
    logic        pc_adv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    logic [31:0] pc_init  = 32'd0;
    logic [31:0] flush_pc = 32'd0;
    logic        data_ovr = 1'b0;
    logic [31:0] ovr_val  = 32'd0;
    int          adv_cnt;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    fetch_buffer #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .pc        (pc),
        .flush     (flush),
        .pcAdvance (pc_adv),
        .memReq    (mem_req),
        .memAddr   (mem_addr),
        .memAck    (mem_ack),
        .memData   (mem_data),
        .instValid (inst_valid),
        .instData  (inst_data),
        .instPc    (inst_pc),
        .instReady (inst_ready)
    );

    always #5 clk = ~clk;

    assign mem_data = data_ovr ? ovr_val : ~mem_addr;

    // pc block model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc <= pc_init;
        else if (flush)  pc <= flush_pc;
        else if (pc_adv) pc <= pc + 32'd4;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      adv_cnt <= 0;
        else if (pc_adv) adv_cnt <= adv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] d);
        exp_t e;
        e.pc   = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each consumed head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (inst_valid && inst_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_inst: got pc %h data %h, want none",
                             inst_pc, inst_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("inst_pc", inst_pc, mon_e.pc);
                    check("inst_data", inst_data, mon_e.data);
                end
            end else if (!inst_valid) begin
                check("idle_inst_pc", inst_pc, 32'd0);
                check("idle_inst_data", inst_data, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset / stream ----------------
        rst_n      = 1'b0;
        pc_init    = 32'h0;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
            check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
            check("rst_inst_pc", inst_pc, 32'd0);
            check("rst_inst_data", inst_data, 32'd0);
            check("rst_pc_adv", {31'd0, pc_adv}, 32'd0);
        end
        step(1);
        rst_n = 1'b1;
        push_exp(32'h0, 32'hFFFF_FFFF);
        push_exp(32'h4, 32'hFFFF_FFFB);
        push_exp(32'h8, 32'hFFFF_FFF7);
        step(1);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        step(1);
        check("b2b_addr", mem_addr, 32'h4);
        step(2);
        mem_ack = 1'b0;
        step(3);
        check("stream_adv_cnt", adv_cnt, 32'd3);
        check("stream_sb_empty", exp_q.size(), 32'd0);
        check("stream_hold_addr", mem_addr, 32'hC);

        // ---------------- backpressure ----------------
        pc_init    = 32'h0;
        inst_ready = 1'b0;
        mem_ack    = 1'b1;
        do_reset();
        push_exp(32'h0, 32'hFFFF_FFFF);
        push_exp(32'h4, 32'hFFFF_FFFB);
        push_exp(32'h8, 32'hFFFF_FFF7);
        step(6);
        check("bp_adv_cnt", adv_cnt, 32'd2);
        check("bp_req_low", {31'd0, mem_req}, 32'd0);
        check("bp_head_pc", inst_pc, 32'h0);
        check("bp_head_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        step(1);
        inst_ready = 1'b0;
        check("bp_refill_req", {31'd0, mem_req}, 32'd1);
        check("bp_refill_addr", mem_addr, 32'h8);
        step(1);
        check("bp_refill_done", {31'd0, mem_req}, 32'd0);
        check("bp_refill_adv", adv_cnt, 32'd3);
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        step(4);
        check("bp_sb_empty", exp_q.size(), 32'd0);

        // ---------------- wait states ----------------
        pc_init    = 32'h10;
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        do_reset();
        push_exp(32'h10, 32'hFFFF_FFEF);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("ws_req_stable", {31'd0, mem_req}, 32'd1);
            check("ws_addr_stable", mem_addr, 32'h10);
        end
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        check("ws_next_addr", mem_addr, 32'h14);
        step(3);
        check("ws_adv_cnt", adv_cnt, 32'd1);
        check("ws_sb_empty", exp_q.size(), 32'd0);

        // ---------------- flush during outstanding fetch ----------------
        pc_init    = 32'h100;
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        do_reset();
        step(2);
        flush    = 1'b1;
        flush_pc = 32'h340C;
        step(1);
        flush = 1'b0;
        check("disc_req_held", {31'd0, mem_req}, 32'd1);
        check("disc_addr_held", mem_addr, 32'h100);
        step(1);
        mem_ack  = 1'b1;
        data_ovr = 1'b1;
        ovr_val  = 32'hDEAD_BEEF;
        step(1);
        mem_ack  = 1'b0;
        data_ovr = 1'b0;
        check("disc_req_drop", {31'd0, mem_req}, 32'd0);
        check("disc_no_adv", adv_cnt, 32'd0);
        push_exp(32'h340C, 32'hFFFF_CBF3);
        step(1);
        check("redir_req", {31'd0, mem_req}, 32'd1);
        check("redir_addr", mem_addr, 32'h340C);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        step(3);
        check("redir_adv_cnt", adv_cnt, 32'd1);
        check("redir_sb_empty", exp_q.size(), 32'd0);

        // ---------------- flush with full FIFO, ack and pop ----------------
        pc_init    = 32'h200;
        inst_ready = 1'b0;
        mem_ack    = 1'b1;
        do_reset();
        step(4);
        check("full_valid", {31'd0, inst_valid}, 32'd1);
        check("full_head_pc", inst_pc, 32'h200);
        inst_ready = 1'b1;
        flush      = 1'b1;
        flush_pc   = 32'h400;
        step(1);
        flush      = 1'b0;
        inst_ready = 1'b0;
        mem_ack    = 1'b0;
        check("fflush_valid", {31'd0, inst_valid}, 32'd0);
        check("fflush_req", {31'd0, mem_req}, 32'd0);
        check("fflush_no_push", adv_cnt, 32'd2);
        step(1);
        check("fflush_redir_req", {31'd0, mem_req}, 32'd1);
        check("fflush_redir_addr", mem_addr, 32'h400);

        // ---------------- async reset mid-request ----------------
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_rst_addr", mem_addr, 32'd0);
        check("async_rst_inst_pc", inst_pc, 32'd0);
        step(1);
        rst_n = 1'b1;

        // ---------------- address wrap and byte-offset masking ----------------
        pc_init    = 32'hFFFF_FFFE;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        push_exp(32'hFFFF_FFFC, 32'h0000_0003);
        step(1);
        check("wrap_first_addr", mem_addr, 32'hFFFF_FFFC);
        step(1);
        check("wrap_next_addr", mem_addr, 32'h0);
        mem_ack = 1'b0;
        step(3);
        check("wrap_adv_cnt", adv_cnt, 32'd1);
        check("wrap_sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
